// File: rtl/reset_sequencer_pkg.sv
// Shared state encoding, default timing constants and sizing helpers for the reset sequencer.
// Combinational definitions only; no latency or flow control.
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_WAIT = 3'd0,
        ST_STAB = 3'd1,
        ST_MEM  = 3'd2,
        ST_CPU  = 3'd3,
        ST_RUN  = 3'd4
    } state_t;

    localparam int LOCK_CYCLES_DEF     = 1024;
    localparam int STAGE_CYCLES_DEF    = 16;
    localparam int DEBOUNCE_CYCLES_DEF = 65536;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed for a counter that runs 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_debounce.sv
// Two-flop synchronizer followed by a debouncer for an asynchronous, bouncing input.
// Output follows the input DEBOUNCE_CYCLES+2 edges after it settles; no flow control.
module sync_debounce
    import reset_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout_db
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        db_d    = db_q;
        dcnt_d  = '0;
        // Counter only survives while the synchronized input keeps disagreeing.
        if (sync2_q != db_q) begin
            if (dcnt_q == DB_LAST) begin
                db_d = sync2_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign dout_db = db_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release (memory/IO, then CPU, then ready) gated on stable PLL lock and an idle button.
// rst_mem falls 2+LOCK_CYCLES edges after lock rises; any lock loss or button press re-asserts all together.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int LOCK_CYCLES     = LOCK_CYCLES_DEF,
    parameter int STAGE_CYCLES    = STAGE_CYCLES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic lock,
    input  logic btn,
    output logic rst_mem,
    output logic rst_cpu,
    output logic ready
);

    localparam int CW = cnt_width(max_int(LOCK_CYCLES, STAGE_CYCLES));
    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYCLES - 1);

    logic          lock_s1_q, lock_s1_d;
    logic          lock_s_q, lock_s_d;
    logic          btn_db;
    logic          abort;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rst_mem_q, rst_mem_d;
    logic          rst_cpu_q, rst_cpu_d;
    logic          ready_q, ready_d;

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (clk),
        .reset  (reset),
        .din    (btn),
        .dout_db(btn_db)
    );

    always_comb begin
        lock_s1_d = lock;
        lock_s_d  = lock_s1_q;
        abort     = !lock_s_q || btn_db;
        state_d   = state_q;
        cnt_d     = '0;

        case (state_q)
            ST_WAIT: begin
                if (!abort) state_d = ST_STAB;
            end
            ST_STAB: begin
                if (cnt_q == LOCK_LAST) state_d = ST_MEM;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            ST_MEM: begin
                if (cnt_q == STAGE_LAST) state_d = ST_CPU;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            ST_CPU: begin
                if (cnt_q == STAGE_LAST) state_d = ST_RUN;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_WAIT;
        endcase

        // Losing lock or a debounced press overrides whatever stage step fired above.
        if (state_q != ST_WAIT && abort) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
        end

        // Outputs decode the next state so they move on the same edge as the FSM.
        rst_mem_d = (state_d == ST_WAIT) || (state_d == ST_STAB);
        rst_cpu_d = rst_mem_d || (state_d == ST_MEM);
        ready_d   = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_s1_q <= 1'b0;
            lock_s_q  <= 1'b0;
            state_q   <= ST_WAIT;
            cnt_q     <= '0;
            rst_mem_q <= 1'b1;
            rst_cpu_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            lock_s1_q <= lock_s1_d;
            lock_s_q  <= lock_s_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_mem_q <= rst_mem_d;
            rst_cpu_q <= rst_cpu_d;
            ready_q   <= ready_d;
        end
    end

    assign rst_mem = rst_mem_q;
    assign rst_cpu = rst_cpu_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed and randomized bench for reset_sequencer with a run-length reference model.
module tb_reset_sequencer;

    localparam int LC = 8;
    localparam int SC = 4;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic reset, lock, btn;
    logic rst_mem, rst_cpu, ready;

    int checks = 0;
    int errors = 0;

    // Model: synchronizer pipelines, debounced button, and the length of the
    // current unbroken run of "lock good and button idle" FSM samples.
    logic m_ls1, m_ls2, m_bs1, m_bs2, m_db;
    int   m_run;
    logic m_hist[$];

    reset_sequencer #(
        .LOCK_CYCLES    (LC),
        .STAGE_CYCLES   (SC),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .lock   (lock),
        .btn    (btn),
        .rst_mem(rst_mem),
        .rst_cpu(rst_cpu),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic l, input logic b);
        logic good;
        logic db_n;
        logic all_diff;
        if (r) begin
            m_ls1 = 0; m_ls2 = 0; m_bs1 = 0; m_bs2 = 0; m_db = 0;
            m_run = 0;
            m_hist.delete();
        end else begin
            good = m_ls2 && !m_db;
            db_n = m_db;
            m_hist.push_back(m_bs2);
            if (m_hist.size() > DC) void'(m_hist.pop_front());
            if (m_hist.size() == DC) begin
                all_diff = 1'b1;
                foreach (m_hist[i]) if (m_hist[i] == m_db) all_diff = 1'b0;
                if (all_diff) db_n = ~m_db;
            end
            m_run = good ? m_run + 1 : 0;
            m_ls2 = m_ls1; m_ls1 = l;
            m_bs2 = m_bs1; m_bs1 = b;
            m_db  = db_n;
        end
    endtask

    task automatic cyc(input logic r, input logic l, input logic b);
        reset = r; lock = l; btn = b;
        @(posedge clk);
        model_step(r, l, b);
        @(negedge clk);
        chk("model_rst_mem", rst_mem, m_run <= LC);
        chk("model_rst_cpu", rst_cpu, m_run <= LC + SC);
        chk("model_ready",   ready,   m_run >  LC + 2 * SC);
        chk("model_btn_db",  dut.btn_db, m_db);
    endtask

    // Lock held high from edge 0 after reset: release edges fixed by the timing rules.
    task automatic seq_check(input string tag);
        for (int e = 0; e < 20; e++) begin
            cyc(0, 1, 0);
            chk({tag, "_rst_mem"}, rst_mem, e < 10);
            chk({tag, "_rst_cpu"}, rst_cpu, e < 14);
            chk({tag, "_ready"},   ready,   e >= 18);
        end
    endtask

    initial begin
        reset = 1; lock = 0; btn = 0;
        m_ls1 = 0; m_ls2 = 0; m_bs1 = 0; m_bs2 = 0; m_db = 0; m_run = 0;

        // Power-up reset and the nominal release sequence.
        repeat (3) cyc(1, 0, 0);
        chk("reset_rst_mem", rst_mem, 1);
        chk("reset_rst_cpu", rst_cpu, 1);
        chk("reset_ready",   ready,   0);
        chk("reset_state",   dut.state_q, 0);
        seq_check("seq1");

        // Lock loss in RUN: all outputs assert together on the third edge.
        cyc(0, 0, 0);
        chk("run_drop_k0_ready", ready, 1);
        cyc(0, 0, 0);
        chk("run_drop_k1_ready", ready, 1);
        chk("run_drop_k1_mem",   rst_mem, 0);
        cyc(0, 0, 0);
        chk("run_drop_k2_mem",   rst_mem, 1);
        chk("run_drop_k2_cpu",   rst_cpu, 1);
        chk("run_drop_k2_ready", ready,   0);

        // One-cycle lock glitch while cnt==5 in STAB restarts the full window.
        repeat (2) cyc(1, 0, 0);
        for (int e = 0; e < 27; e++) begin
            cyc(0, (e == 6) ? 1'b0 : 1'b1, 0);
            if (e == 7) chk("glitch_cnt5", dut.cnt_q, 5);
            if (e == 8) chk("glitch_wait", dut.state_q, 0);
            if (e < 18) chk("glitch_rst_mem", rst_mem, e < 17);
        end
        chk("glitch_ready_run", ready, 1);

        // Bouncing button never debounces; a held press aborts RUN.
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, ~i[0]);
            chk("bounce_db",    dut.btn_db, 0);
            chk("bounce_ready", ready, 1);
        end
        for (int j = 0; j < 7; j++) begin
            cyc(0, 1, 1);
            chk("press_db",      dut.btn_db, j >= 5);
            chk("press_ready",   ready,   j < 6);
            chk("press_rst_mem", rst_mem, j >= 6);
            chk("press_rst_cpu", rst_cpu, j >= 6);
        end
        repeat (12) cyc(0, 1, 0);

        // Abort and MEM->CPU step in the same cycle: abort wins.
        repeat (2) cyc(1, 0, 0);
        for (int e = 0; e < 16; e++) begin
            cyc(0, (e == 12) ? 1'b0 : 1'b1, 0);
            if (e == 13) begin
                chk("memab_state_mem", dut.state_q, 2);
                chk("memab_cnt3",      dut.cnt_q, 3);
            end
            if (e == 14) begin
                chk("memab_state_wait", dut.state_q, 0);
                chk("memab_rst_cpu",    rst_cpu, 1);
                chk("memab_rst_mem",    rst_mem, 1);
            end
        end

        // Block reset in CPU, then the whole sequence again.
        repeat (2) cyc(1, 0, 0);
        for (int e = 0; e < 15; e++) cyc(0, 1, 0);
        chk("cpu_state", dut.state_q, 3);
        cyc(1, 1, 0);
        chk("cpu_rst_mem", rst_mem, 1);
        chk("cpu_rst_cpu", rst_cpu, 1);
        chk("cpu_ready",   ready,   0);
        seq_check("seq2");

        // Randomized segments of stable lock, lock drops, presses and resets.
        for (int n = 0; n < 80; n++) begin
            int mode;
            int len;
            mode = $urandom_range(0, 9);
            if (mode < 5) begin
                len = $urandom_range(5, 40);
                repeat (len) cyc(0, 1, 0);
            end else if (mode < 7) begin
                len = $urandom_range(1, 3);
                repeat (len) cyc(0, 0, 0);
            end else if (mode < 9) begin
                len = $urandom_range(1, 8);
                repeat (len) cyc(0, 1, 1'($urandom_range(0, 1)));
                repeat (len) cyc(0, 1, 1);
            end else begin
                len = $urandom_range(1, 2);
                repeat (len) cyc(1, 1'($urandom_range(0, 1)), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter LOCK_CYCLES, default 1024, is the number of clk cycles PLL lock must hold stable before the first reset stage is released (at least 2).
REQ-002 Parameter STAGE_CYCLES, default 16, is the clk-cycle gap between successive reset-stage releases (at least 2).
REQ-003 Parameter DEBOUNCE_CYCLES, default 65536, is the number of clk cycles the synchronized button must be stable before its debounced value changes (at least 2).
REQ-004 clk  input  1  system clock (PLL global output, 33.333 MHz nominal); all logic is on its rising edge.
REQ-005 reset  input  1  synchronous, active-high block reset.
REQ-006 lock  input  1  PLL LOCK, asynchronous to clk; high means locked.
REQ-007 btn  input  1  user reset button, asynchronous, active-high, bouncing.
REQ-008 rst_mem  output  1  active-high synchronous reset for memory/IO, registered.
REQ-009 rst_cpu  output  1  active-high synchronous reset for the MIX CPU core, registered.
REQ-010 ready  output  1  high only in RUN, registered.

Function
REQ-011 lock and btn SHALL each pass through a 2-flop synchronizer (lock_s, btn_s) before any other use.
REQ-012 btn_db SHALL change to btn_s only after btn_s differs from btn_db for DEBOUNCE_CYCLES consecutive cycles; any return to equality clears the debounce counter.
REQ-013 The FSM SHALL have states WAIT, STAB, MEM, CPU, RUN, with one shared counter cnt sized for max(LOCK_CYCLES, STAGE_CYCLES).
REQ-014 WAIT: rst_mem=1, rst_cpu=1, ready=0, cnt=0; go to STAB when lock_s=1 and btn_db=0.
REQ-015 STAB: cnt increments each cycle; at cnt==LOCK_CYCLES-1, go to MEM, clear cnt, and drive rst_mem=0 from the next cycle.
REQ-016 MEM: at cnt==STAGE_CYCLES-1, go to CPU, clear cnt, and drive rst_cpu=0.
REQ-017 CPU: at cnt==STAGE_CYCLES-1, go to RUN and drive ready=1.
REQ-018 RUN: hold; cnt stays at 0.
REQ-019 Abort: in any state other than WAIT, lock_s=0 or btn_db=1 SHALL force WAIT on the next edge, with rst_mem=1, rst_cpu=1, ready=0 and cnt=0 on that same edge. Abort takes priority over every stage transition that fires in the same cycle.
REQ-020 A lock glitch of one or more synchronized cycles during STAB SHALL restart the full LOCK_CYCLES window; there is no partial credit.
REQ-021 Reset outputs SHALL release only in the order rst_mem, then rst_cpu, then ready, and SHALL assert simultaneously.
REQ-022 Latency: if lock rises before edge k and btn_db=0, then rst_mem falls at edge k+2+LOCK_CYCLES, rst_cpu at k+2+LOCK_CYCLES+STAGE_CYCLES, and ready at k+2+LOCK_CYCLES+2*STAGE_CYCLES.
REQ-023 No output SHALL glitch; every output comes directly from a flop.

Reset
REQ-024 While reset=1 at an edge: state=WAIT, cnt=0, debounce counter=0, synchronizer flops=0, btn_db=0, rst_mem=1, rst_cpu=1, ready=0.
REQ-025 Reset mid-sequence, including in RUN, SHALL behave exactly like an abort and SHALL restart the sequence from WAIT after reset falls.

Structure
REQ-026 A shared package SHALL hold the state encoding (WAIT=0, STAB=1, MEM=2, CPU=3, RUN=4, 3 bits) and the default cycle constants.
REQ-027 One sub-module, sync_debounce, SHALL implement the 2-flop synchronizer plus debounce counter; it SHALL be instantiated once for btn, and lock SHALL use only a bare 2-flop synchronizer.

Verification (LOCK_CYCLES=8, STAGE_CYCLES=4, DEBOUNCE_CYCLES=4)
REQ-028 Bench: reset for 3 cycles, then lock=1 before edge 0 -> rst_mem falls at edge 10, rst_cpu at edge 14, ready at edge 18; outputs are 1/1/0 before those edges.
REQ-029 Bench: lock drops for 1 cycle while cnt=5 in STAB -> state returns to WAIT, and rst_mem then falls 8 cycles after re-entry to STAB, not sooner.
REQ-030 Bench: in RUN, lock=0 -> rst_mem=1, rst_cpu=1, ready=0 all at the same edge, 3 edges after lock falls.
REQ-031 Bench: btn toggles every cycle for 20 cycles -> btn_db stays 0 and ready stays 1; btn held high 4 stable synchronized cycles -> btn_db=1 and all resets assert.
REQ-032 Bench: in MEM, lock_s=0 in the same cycle cnt==3 -> state=WAIT and rst_cpu remains 1 (abort beats transition).
REQ-033 Bench: reset=1 asserted in CPU -> outputs 1/1/0 at the next edge, and the full sequence repeats after reset falls.
